// File: rtl/dmem_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dmem_lsu                                                   |
// | Purpose  : Single-outstanding RISC-V load/store unit wrapped around a |
// |            word-organised data RAM, with configurable response      |
// |            latency, byte-enable stores, sign/zero-extending loads   |
// |            and error reporting for bad size, alignment or range.    |
// | Revision : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         c_AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] c_CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_lane;
  logic [c_AW-1:0]   r_idx;
  logic              r_bad;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  // Data RAM: zero at power-up, deliberately outside the reset domain.
  logic [31:0]       r_mem [DEPTH_WORDS] = '{default: '0};

  logic              w_accept;
  logic              w_bad;
  logic              w_oob;
  logic              w_store;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_rep;
  logic [c_AW-1:0]   w_req_idx;
  logic              w_sel_bad;
  logic              w_sel_we;
  logic [2:0]        w_sel_f3;
  logic [1:0]        w_sel_lane;
  logic [c_AW-1:0]   w_sel_idx;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_rsp_rdata_nxt;

  // Pick the byte/half lane out of a word and extend it to 32 bits.
  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  f_extract = {{24{b[7]}}, b};
      3'b001:  f_extract = {{16{h[15]}}, h};
      3'b100:  f_extract = {24'd0, b};
      3'b101:  f_extract = {16'd0, h};
      default: f_extract = word;
    endcase
  endfunction

  // Handshake: only IDLE accepts, and never while reset is held.
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign w_accept  = req_valid && (r_state == S_IDLE) && !rst;
  assign w_req_idx = req_addr[c_AW+1:2];
  assign w_oob     = |req_addr[31:c_AW+2];

  // Classify the incoming request: illegal size code, misalignment or range.
  always_comb begin
    w_bad = 1'b0;
    case (req_funct3)
      3'b000:  w_bad = 1'b0;
      3'b001:  w_bad = req_addr[0];
      3'b010:  w_bad = (req_addr[1:0] != 2'b00);
      3'b100:  w_bad = req_we;
      3'b101:  w_bad = req_we || req_addr[0];
      default: w_bad = 1'b1;
    endcase
    w_bad = w_bad || w_oob;
  end

  // Byte enables and lane-replicated store data from size and address.
  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be        = 4'b0001 << req_addr[1:0];
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_wdata_rep = req_wdata;
      end
    endcase
  end

  assign w_store = w_accept && req_we && !w_bad;

  // With single-edge latency the response is formed straight from the
  // live request; otherwise from the fields captured at accept.
  assign w_sel_bad  = (r_state == S_IDLE) ? w_bad           : r_bad;
  assign w_sel_we   = (r_state == S_IDLE) ? req_we          : r_we;
  assign w_sel_f3   = (r_state == S_IDLE) ? req_funct3      : r_f3;
  assign w_sel_lane = (r_state == S_IDLE) ? req_addr[1:0]   : r_lane;
  assign w_sel_idx  = (r_state == S_IDLE) ? w_req_idx       : r_idx;
  assign w_rd_word  = r_mem[w_sel_idx];

  assign w_rsp_rdata_nxt = (w_sel_bad || w_sel_we) ? 32'd0
                         : f_extract(w_rd_word, w_sel_f3, w_sel_lane);

  // Legal stores commit at the accept edge through the byte enables.
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_req_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
        end
      end
    end
  end

  // Transaction FSM: IDLE -> (WAIT) -> RESP -> IDLE; response registers
  // are loaded on the edge entering RESP and held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_we        <= 1'b0;
      r_f3        <= 3'd0;
      r_lane      <= 2'd0;
      r_idx       <= '0;
      r_bad       <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we   <= req_we;
            r_f3   <= req_funct3;
            r_lane <= req_addr[1:0];
            r_idx  <= w_req_idx;
            r_bad  <= w_bad;
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_err   <= w_sel_bad;
              r_rsp_rdata <= w_rsp_rdata_nxt;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state     <= S_RESP;
            r_rsp_err   <= w_sel_bad;
            r_rsp_rdata <= w_rsp_rdata_nxt;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set memory depth in 32-bit words (power of two, 16..65536).
REQ-002 Parameter LATENCY, default 1, SHALL set the number of clock edges from request accept to response valid (legal 1..4).
REQ-003 Ports: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RISC-V access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  consumer takes response.
REQ-013 rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  out  1  misaligned, out-of-range or illegal funct3.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; one transaction outstanding at most.
REQ-016 Accept = req_valid && req_ready at a rising edge; addr, we, funct3 and wdata SHALL be captured at accept.
REQ-017 At accept: LATENCY=1 -> RESP; else -> WAIT with counter = LATENCY-2, decrementing each edge; WAIT -> RESP when counter is 0.
REQ-018 rsp_valid SHALL rise exactly LATENCY edges after the accept edge, and SHALL equal 1 iff state is RESP.
REQ-019 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1; then -> IDLE, so the next accept is possible no earlier than 1 cycle later.
REQ-020 Error conditions: funct3 not in the legal set (stores: only 000/001/010); H/HU with addr[0]=1; W with addr[1:0]!=0; word index addr[31:2] >= DEPTH_WORDS.
REQ-021 An erroring request SHALL NOT modify memory, and SHALL respond rsp_err=1, rsp_rdata=0.
REQ-022 A legal store SHALL commit at the accept edge using byte enables: SB writes the byte at lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all 4 lanes. Other lanes SHALL be unchanged.
REQ-023 A legal load SHALL sample its memory word at the edge entering RESP, so a store accepted earlier is always visible.
REQ-024 Load extraction: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged; little-endian.
REQ-025 A store response SHALL be rsp_err=0, rsp_rdata=0.
REQ-026 req_valid arriving while busy SHALL be ignored, with no side effects, until req_ready=1.
REQ-027 Memory contents SHALL initialise to zero at time 0 and SHALL NOT be cleared by rst.

Reset
REQ-028 While rst=1: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 (immediately, without waiting for a clock edge).
REQ-029 Reset in WAIT/RESP SHALL discard the in-flight response; a store already committed at accept SHALL persist.
REQ-030 An accept SHALL NOT occur on an edge at which rst=1.

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10, LATENCY=1 -> store rsp 1 cycle after accept, err=0; load rsp 0xDEADBEEF.
REQ-032 SB 0x7F @0x21, SB 0x80 @0x22 onto a zeroed word, then LB @0x22 -> 0xFFFFFF80; LBU @0x22 -> 0x00000080; LW @0x20 -> 0x00807F00.
REQ-033 LH @0x13, SW @0x2, funct3=011 load, LW @(DEPTH_WORDS*4) -> each rsp_err=1, rsp_rdata=0; memory unchanged.
REQ-034 LATENCY=3, load with rsp_ready=0 for 5 cycles -> rsp_valid rises 3 edges after accept, data stable while stalled, req_ready=0 throughout, req_valid pulses ignored.
REQ-035 rst asserted in WAIT after SW 0x12345678 @0x40 -> rsp_valid 0 and req_ready 1 immediately; after release, LW @0x40 -> 0x12345678.
